decoder_seq: RTL and testbench

DECODER_SEQ -- requirements
Module: decoder_seq

---
 rtl/decoder_pkg.sv | 19 +
 rtl/decoder_dwell_timer.sv | 30 +++
 rtl/decoder_seq.sv | 125 ++++++++++++
 tb/tb_decoder_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared encodings for the sequenced one-hot decoder: operating modes seen on
// the mode port and the controller state encoding.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT  = 2'b00,
        MODE_SCAN_UP = 2'b01,
        MODE_SCAN_DN = 2'b10,
        MODE_SWEEP   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DIRECT = 2'b01,
        ST_SCAN   = 2'b10,
        ST_SWEEP  = 2'b11
    } state_e;

endpackage

// File: rtl/decoder_dwell_timer.sv
// Dwell timer: counts run cycles and flags the last cycle of each DWELL-long
// interval; the count wraps to zero on expiry so every index starts fresh.
module decoder_dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign expire = run && !clear && (cnt == LAST);

endmodule

// File: rtl/decoder_seq.sv
// Sequenced one-hot decoder: direct decode, up/down scanning and a one-shot
// sweep with busy/done handshake. All outputs are registered.
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  start,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      idx,
    output logic                  busy,
    output logic                  done
);

    localparam int OUT_W = 2**SEL_W;

    state_e             state, state_next;
    mode_e              mode_q, mode_next, mode_in;
    logic [SEL_W-1:0]   idx_next;
    logic [OUT_W-1:0]   y_next;
    logic               busy_next, done_next, y_on;
    logic               entry, run, clear, expire;

    assign mode_in = mode_e'(mode);

    // A mode is (re)entered after reset, after en was low, or on any mode change.
    assign entry = (state == ST_IDLE) || (mode_in != mode_q);
    assign run   = en && !entry && ((state == ST_SCAN) || (state == ST_SWEEP && busy));
    assign clear = !run;

    decoder_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .run    (run),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            mode_q <= MODE_DIRECT;
            y      <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            mode_q <= mode_next;
            y      <= y_next;
            idx    <= idx_next;
            busy   <= busy_next;
            done   <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        mode_next  = mode_q;
        idx_next   = idx;
        busy_next  = busy;
        done_next  = 1'b0;
        y_on       = 1'b0;

        if (!en) begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
        end else begin
            mode_next = mode_in;
            case (mode_in)
                MODE_DIRECT: begin
                    state_next = ST_DIRECT;
                    busy_next  = 1'b0;
                    idx_next   = sel;
                    y_on       = 1'b1;
                end
                MODE_SCAN_UP, MODE_SCAN_DN: begin
                    state_next = ST_SCAN;
                    busy_next  = 1'b0;
                    y_on       = 1'b1;
                    if (entry) begin
                        idx_next = (mode_in == MODE_SCAN_UP) ? '0 : '1;
                    end else if (expire) begin
                        idx_next = (mode_in == MODE_SCAN_UP) ? idx + SEL_W'(1)
                                                             : idx - SEL_W'(1);
                    end
                end
                default: begin
                    state_next = ST_SWEEP;
                    if (entry || !busy) begin
                        // Sweep armed: a start launches at index 0 on the next cycle.
                        busy_next = 1'b0;
                        if (start) begin
                            busy_next = 1'b1;
                            idx_next  = '0;
                            y_on      = 1'b1;
                        end
                    end else begin
                        y_on = 1'b1;
                        if (expire) begin
                            if (&idx) begin
                                busy_next = 1'b0;
                                done_next = 1'b1;
                                y_on      = 1'b0;
                            end else begin
                                idx_next = idx + SEL_W'(1);
                            end
                        end
                    end
                end
            endcase
        end

        y_next = y_on ? (OUT_W'(1) << idx_next) : '0;
    end

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq: directed tables and sequences on an 8-output, dwell-2
// instance, randomized traffic against a reference model, and a 4-output dwell-1 scan.
module tb_decoder_seq;

    localparam int SA = 3, DA = 2, OA = 8;
    localparam int SB = 2, DB = 1, OB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          en_a = 1'b0, start_a = 1'b0;
    logic [1:0]    mode_a = 2'd0;
    logic [SA-1:0] sel_a = '0;
    logic [OA-1:0] y_a;
    logic [SA-1:0] idx_a;
    logic          busy_a, done_a;

    logic          en_b = 1'b0, start_b = 1'b0;
    logic [1:0]    mode_b = 2'd0;
    logic [SB-1:0] sel_b = '0;
    logic [OB-1:0] y_b;
    logic [SB-1:0] idx_b;
    logic          busy_b, done_b;

    int total = 0;
    int bad   = 0;

    decoder_seq #(.SEL_W(SA), .DWELL(DA)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .sel(sel_a), .start(start_a),
        .y(y_a), .idx(idx_a), .busy(busy_a), .done(done_a)
    );

    decoder_seq #(.SEL_W(SB), .DWELL(DB)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .sel(sel_b), .start(start_b),
        .y(y_b), .idx(idx_b), .busy(busy_b), .done(done_b)
    );

    // y is zero or exactly the bit selected by idx, on every cycle.
    always @(negedge clk) begin
        total++;
        assert ((y_a == '0) || (y_a == (OA'(1) << idx_a))) else begin
            bad++;
            $display("FAIL onehot_a t=%0t y=%h idx=%0d", $time, y_a, idx_a);
        end
        total++;
        assert ((y_b == '0) || (y_b == (OB'(1) << idx_b))) else begin
            bad++;
            $display("FAIL onehot_b t=%0t y=%h idx=%0d", $time, y_b, idx_b);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic step_a(input logic e, input logic [1:0] m, input logic [SA-1:0] s, input logic st);
        en_a = e; mode_a = m; sel_a = s; start_a = st;
        @(posedge clk); #1;
    endtask

    task automatic step_b(input logic e, input logic [1:0] m);
        en_b = e; mode_b = m; sel_b = '0; start_b = 1'b0;
        @(posedge clk); #1;
    endtask

    // Reference model for the 8-output instance, in terms of cycles since entry/launch.
    int m_prev, m_k;
    bit m_sw;
    int e_y, e_idx, e_busy, e_done;

    function automatic void model_reset();
        m_prev = -1; m_k = 0; m_sw = 0;
        e_y = 0; e_idx = 0; e_busy = 0; e_done = 0;
    endfunction

    function automatic void model_step(bit e, int m, int s, bit st);
        bit entry;
        int pos;
        e_done = 0;
        if (!e) begin
            e_y = 0; e_busy = 0; m_prev = -1; m_sw = 0;
            return;
        end
        entry  = (m != m_prev);
        m_prev = m;
        case (m)
            0: begin
                e_idx = s; e_y = 1 << s; e_busy = 0; m_sw = 0;
            end
            1, 2: begin
                m_k   = entry ? 0 : m_k + 1;
                pos   = (m_k / DA) % OA;
                e_idx = (m == 1) ? pos : OA - 1 - pos;
                e_y   = 1 << e_idx; e_busy = 0; m_sw = 0;
            end
            default: begin
                if (entry) m_sw = 0;
                if (m_sw) begin
                    m_k++;
                    if (m_k == OA * DA) begin
                        m_sw = 0; e_done = 1; e_y = 0; e_busy = 0;
                    end else begin
                        e_idx = m_k / DA; e_y = 1 << e_idx; e_busy = 1;
                    end
                end else if (st) begin
                    m_sw = 1; m_k = 0; e_idx = 0; e_y = 1; e_busy = 1;
                end else begin
                    e_y = 0; e_busy = 0;
                end
            end
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        en_a = 1'b0; mode_a = 2'd0; sel_a = '0; start_a = 1'b0;
        en_b = 1'b0; mode_b = 2'd0; sel_b = '0; start_b = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic          en;
        logic [1:0]    mode;
        logic [SA-1:0] sel;
        logic          start;
        logic [OA-1:0] y;
        logic [SA-1:0] idx;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int busy_cnt;
        int cur_mode;
        bit e, st;
        int s;

        tbl.push_back('{1'b1, 2'd0, 3'd0, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2'd0, 3'd2, 1'b0, 8'h04, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2'd0, 3'd4, 1'b0, 8'h10, 3'd4, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2'd0, 3'd6, 1'b0, 8'h40, 3'd6, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 3'd1, 1'b0, 8'h00, 3'd6, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2'd2, 3'd0, 1'b0, 8'h80, 3'd7, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2'd2, 3'd3, 1'b0, 8'h80, 3'd7, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2'd2, 3'd0, 1'b1, 8'h40, 3'd6, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2'd2, 3'd0, 1'b0, 8'h40, 3'd6, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2'd2, 3'd0, 1'b0, 8'h20, 3'd5, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 2'd2, 3'd0, 1'b0, 8'h20, 3'd5, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 2'd2, 3'd0, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0});

        // Asynchronous reset state, before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("rst_y", 32'(y_a), 0);
        check("rst_idx", 32'(idx_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            step_a(tbl[i].en, tbl[i].mode, tbl[i].sel, tbl[i].start);
            check($sformatf("tbl%0d_y", i), 32'(y_a), 32'(tbl[i].y));
            check($sformatf("tbl%0d_idx", i), 32'(idx_a), 32'(tbl[i].idx));
            check($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_done", i), 32'(done_a), 32'(tbl[i].done));
        end

        // Scan up for 20 cycles with wrap.
        for (int k = 0; k < 20; k++) begin
            step_a(1'b1, 2'd1, '0, 1'b0);
            check($sformatf("scanup_idx%0d", k), 32'(idx_a), 32'((k / DA) % OA));
            check($sformatf("scanup_y%0d", k), 32'(y_a), 32'(1 << ((k / DA) % OA)));
        end

        // Sweep: armed, launch, ignored second start, done pulse.
        step_a(1'b0, 2'd0, '0, 1'b0);
        step_a(1'b1, 2'd3, '0, 1'b0);
        check("sweep_armed_y", 32'(y_a), 0);
        check("sweep_armed_busy", 32'(busy_a), 0);
        busy_cnt = 0;
        step_a(1'b1, 2'd3, '0, 1'b1);
        check("sweep_launch_y", 32'(y_a), 1);
        check("sweep_launch_idx", 32'(idx_a), 0);
        if (busy_a) busy_cnt++;
        for (int k = 1; k < OA * DA; k++) begin
            step_a(1'b1, 2'd3, '0, (k == 5));
            check($sformatf("sweep_y%0d", k), 32'(y_a), 32'(1 << (k / DA)));
            check($sformatf("sweep_done%0d", k), 32'(done_a), 0);
            if (busy_a) busy_cnt++;
        end
        step_a(1'b1, 2'd3, '0, 1'b0);
        check("sweep_end_y", 32'(y_a), 0);
        check("sweep_end_busy", 32'(busy_a), 0);
        check("sweep_end_done", 32'(done_a), 1);
        check("sweep_busy_len", busy_cnt, OA * DA);
        step_a(1'b1, 2'd3, '0, 1'b0);
        check("sweep_done_once", 32'(done_a), 0);
        check("sweep_idle_y", 32'(y_a), 0);

        // Abort a sweep by switching to scan-up.
        step_a(1'b1, 2'd3, '0, 1'b1);
        for (int k = 0; k < 5; k++) step_a(1'b1, 2'd3, '0, 1'b0);
        step_a(1'b1, 2'd1, '0, 1'b0);
        check("abort_y", 32'(y_a), 1);
        check("abort_idx", 32'(idx_a), 0);
        check("abort_busy", 32'(busy_a), 0);
        check("abort_done", 32'(done_a), 0);
        for (int k = 0; k < 3; k++) begin
            step_a(1'b1, 2'd1, '0, 1'b0);
            check($sformatf("abort_nodone%0d", k), 32'(done_a), 0);
        end

        // Reset mid-scan acts without a clock edge; first cycle after is a fresh entry.
        for (int k = 0; k < 5; k++) step_a(1'b1, 2'd1, '0, 1'b0);
        rst = 1'b1;
        #2;
        check("rstscan_y", 32'(y_a), 0);
        check("rstscan_idx", 32'(idx_a), 0);
        #1 rst = 1'b0;
        step_a(1'b1, 2'd1, '0, 1'b0);
        check("rstscan_entry_y", 32'(y_a), 1);
        check("rstscan_entry_idx", 32'(idx_a), 0);

        // Reset mid-sweep gives no done pulse.
        step_a(1'b1, 2'd3, '0, 1'b1);
        for (int k = 0; k < 4; k++) step_a(1'b1, 2'd3, '0, 1'b0);
        rst = 1'b1;
        #2;
        check("rstsweep_busy", 32'(busy_a), 0);
        check("rstsweep_done", 32'(done_a), 0);
        #1 rst = 1'b0;
        step_a(1'b1, 2'd3, '0, 1'b0);
        check("rstsweep_after_done", 32'(done_a), 0);
        check("rstsweep_after_y", 32'(y_a), 0);

        // Small instance: dwell of one advances every cycle.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step_b(1'b1, 2'd1);
            check($sformatf("b_scanup_idx%0d", k), 32'(idx_b), 32'(k % OB));
            check($sformatf("b_scanup_y%0d", k), 32'(y_b), 32'(1 << (k % OB)));
        end
        step_b(1'b0, 2'd0);

        // Randomized traffic against the reference model.
        do_reset();
        cur_mode = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(24, 0) == 0) cur_mode = int'($urandom_range(3, 0));
            e  = ($urandom_range(29, 0) != 0);
            s  = int'($urandom_range(OA - 1, 0));
            st = ($urandom_range(4, 0) == 0);
            model_step(e, cur_mode, s, st);
            step_a(e, 2'(cur_mode), SA'(s), st);
            check($sformatf("rnd%0d_y", i), 32'(y_a), 32'(e_y));
            check($sformatf("rnd%0d_idx", i), 32'(idx_a), 32'(e_idx));
            check($sformatf("rnd%0d_busy", i), 32'(busy_a), 32'(e_busy));
            check($sformatf("rnd%0d_done", i), 32'(done_a), 32'(e_done));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
